// File: rtl/mips_pkg.sv
// Shared MIPS constants: opcode/funct codes, instruction field bit positions and
// the fetch/decode FSM state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_BREAK = 6'b001101;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 26;
  localparam int unsigned RS_MSB = 25;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;
  localparam int unsigned RD_MSB = 15;
  localparam int unsigned RD_LSB = 11;
  localparam int unsigned SH_MSB = 10;
  localparam int unsigned SH_LSB = 6;
  localparam int unsigned FN_MSB = 5;
  localparam int unsigned FN_LSB = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  function automatic logic is_break(input logic [31:0] word);
    return (word[OP_MSB:OP_LSB] == OP_RTYPE) && (word[FN_MSB:FN_LSB] == F_BREAK);
  endfunction

endpackage

// File: rtl/mips_imem.sv
// Instruction memory: DEPTH x 32 array, synchronous write, combinational read.
// Contents are deliberately not reset.
module mips_imem #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_fetch_decode.sv
// Sequential fetch + field decode with valid/ready output, halting on BREAK.
// Optional MIPS_FD_SKIP_NONR_EN: drop non-R-type words and count them on skip_cnt.
module mips_fetch_decode
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_waddr,
  input  logic [31:0]   imem_wdata,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [5:0]    opcode,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    rd,
  output logic [4:0]    shamt,
  output logic [5:0]    funct,
  output logic          is_rtype,
  output logic [31:0]   pc_out,
  output logic          halted
`ifdef MIPS_FD_SKIP_NONR_EN
  ,
  output logic [15:0]   skip_cnt
`endif
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] word_q, word_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        is_rtype_q, is_rtype_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [31:0] fetch_word;
  logic        slot;

`ifdef MIPS_FD_SKIP_NONR_EN
  logic [15:0] skip_q, skip_d;
`endif

  // Writes are blocked in RUN so the fetch path never races a program load.
  mips_imem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_imem (
    .clk  (clk),
    .we   (imem_we && (state_q != ST_RUN)),
    .waddr(imem_waddr),
    .wdata(imem_wdata),
    .raddr(pc_q[AW+1:2]),
    .rdata(fetch_word)
  );

  assign slot = !valid_q || out_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    word_d     = word_q;
    pc_out_d   = pc_out_q;
    is_rtype_d = is_rtype_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
`ifdef MIPS_FD_SKIP_NONR_EN
    skip_d     = skip_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (slot) begin
          if (is_break(fetch_word)) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
            valid_d  = 1'b0;
`ifdef MIPS_FD_SKIP_NONR_EN
          end else if (fetch_word[OP_MSB:OP_LSB] != OP_RTYPE) begin
            pc_d    = pc_q + 32'd4;
            valid_d = 1'b0;
            if (skip_q != 16'hFFFF) skip_d = skip_q + 16'd1;
`endif
          end else begin
            word_d     = fetch_word;
            is_rtype_d = (fetch_word[OP_MSB:OP_LSB] == OP_RTYPE);
            pc_out_d   = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + 32'd4;
          end
        end
      end
      default: begin
        if (valid_q && out_ready) valid_d = 1'b0;
        if (start) begin
          state_d  = ST_RUN;
          pc_d     = 32'd0;
          halted_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= 32'd0;
      word_q     <= 32'd0;
      pc_out_q   <= 32'd0;
      is_rtype_q <= 1'b0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
`ifdef MIPS_FD_SKIP_NONR_EN
      skip_q     <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      word_q     <= word_d;
      pc_out_q   <= pc_out_d;
      is_rtype_q <= is_rtype_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
`ifdef MIPS_FD_SKIP_NONR_EN
      skip_q     <= skip_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign opcode    = word_q[OP_MSB:OP_LSB];
  assign rs        = word_q[RS_MSB:RS_LSB];
  assign rt        = word_q[RT_MSB:RT_LSB];
  assign rd        = word_q[RD_MSB:RD_LSB];
  assign shamt     = word_q[SH_MSB:SH_LSB];
  assign funct     = word_q[FN_MSB:FN_LSB];
  assign is_rtype  = is_rtype_q;
  assign pc_out    = pc_out_q;
  assign halted    = halted_q;
`ifdef MIPS_FD_SKIP_NONR_EN
  assign skip_cnt  = skip_q;
`endif

endmodule

// File: tb/tb_mips_fetch_decode.sv
// Directed bench for mips_fetch_decode: a DEPTH=64 instance for the main flows and a
// DEPTH=4 instance for fetch wrap-around.
module tb_mips_fetch_decode;

  localparam logic [31:0] W_ADD0 = 32'h00463820;  // add rd7, rs2, rt6
  localparam logic [31:0] W_ADD1 = 32'h00E41820;  // add rd3, rs7, rt4
  localparam logic [31:0] W_BRK  = 32'h0000000D;
  localparam logic [31:0] W_LW   = 32'h8C220004;
  localparam logic [31:0] W_NEW1 = 32'h012A4020;  // add rd8, rs9, rt10

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_we = 1'b0;
  logic [5:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic        out_ready = 1'b0;
  logic        out_valid, is_rtype, halted;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] pc_out;
`ifdef MIPS_FD_SKIP_NONR_EN
  logic [15:0] skip_cnt;
  logic [15:0] d4_skip_cnt;
`endif

  logic        d4_start = 1'b0;
  logic        d4_we = 1'b0;
  logic [1:0]  d4_waddr = '0;
  logic [31:0] d4_wdata = '0;
  logic        d4_valid, d4_is_rtype, d4_halted;
  logic [5:0]  d4_opcode, d4_funct;
  logic [4:0]  d4_rs, d4_rt, d4_rd, d4_shamt;
  logic [31:0] d4_pc_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mips_fetch_decode #(.DEPTH(64), .AW(6)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .imem_we   (imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .opcode    (opcode),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .funct     (funct),
    .is_rtype  (is_rtype),
    .pc_out    (pc_out),
    .halted    (halted)
`ifdef MIPS_FD_SKIP_NONR_EN
    ,
    .skip_cnt  (skip_cnt)
`endif
  );

  mips_fetch_decode #(.DEPTH(4), .AW(2)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (d4_start),
    .imem_we   (d4_we),
    .imem_waddr(d4_waddr),
    .imem_wdata(d4_wdata),
    .out_ready (1'b1),
    .out_valid (d4_valid),
    .opcode    (d4_opcode),
    .rs        (d4_rs),
    .rt        (d4_rt),
    .rd        (d4_rd),
    .shamt     (d4_shamt),
    .funct     (d4_funct),
    .is_rtype  (d4_is_rtype),
    .pc_out    (d4_pc_out),
    .halted    (d4_halted)
`ifdef MIPS_FD_SKIP_NONR_EN
    ,
    .skip_cnt  (d4_skip_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
    step();
    imem_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_pc_out", pc_out, 32'd0);
    check("reset_is_rtype", 32'(is_rtype), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic run with out_ready high
    load(6'd0, W_ADD0); load(6'd1, W_ADD1); load(6'd2, W_BRK);
    out_ready = 1'b1;
    do_start();
    check("lat_no_valid_yet", 32'(out_valid), 32'd0);
    step();
    check("i0_valid", 32'(out_valid), 32'd1);
    check("i0_opcode", 32'(opcode), 32'd0);
    check("i0_rs", 32'(rs), 32'd2);
    check("i0_rt", 32'(rt), 32'd6);
    check("i0_rd", 32'(rd), 32'd7);
    check("i0_shamt", 32'(shamt), 32'd0);
    check("i0_funct", 32'(funct), 32'h20);
    check("i0_is_rtype", 32'(is_rtype), 32'd1);
    check("i0_pc", pc_out, 32'd0);
    step();
    check("i1_valid", 32'(out_valid), 32'd1);
    check("i1_rs", 32'(rs), 32'd7);
    check("i1_rt", 32'(rt), 32'd4);
    check("i1_rd", 32'(rd), 32'd3);
    check("i1_pc", pc_out, 32'd4);
    check("i1_halted", 32'(halted), 32'd0);
    step();
    check("brk_valid", 32'(out_valid), 32'd0);
    check("brk_halted", 32'(halted), 32'd1);

    // Backpressure: first word held for 5 cycles, then issue resumes at pc 4
    out_ready = 1'b0;
    do_start();
    check("restart_halted_clr", 32'(halted), 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_pc", pc_out, 32'd0);
      check("stall_rs", 32'(rs), 32'd2);
      step();
    end
    out_ready = 1'b1;
    step();
    check("resume_valid", 32'(out_valid), 32'd1);
    check("resume_pc", pc_out, 32'd4);
    check("resume_rd", 32'(rd), 32'd3);
    step();
    check("bp_halted", 32'(halted), 32'd1);
    check("bp_valid", 32'(out_valid), 32'd0);

    // Non-R-type word
    load(6'd0, W_LW); load(6'd1, W_BRK);
    do_start();
    step();
`ifdef MIPS_FD_SKIP_NONR_EN
    check("skip_valid", 32'(out_valid), 32'd0);
    check("skip_cnt", 32'(skip_cnt), 32'd1);
    step();
    check("skip_halted", 32'(halted), 32'd1);
    check("skip_cnt_hold", 32'(skip_cnt), 32'd1);
`else
    check("lw_valid", 32'(out_valid), 32'd1);
    check("lw_opcode", 32'(opcode), 32'h23);
    check("lw_is_rtype", 32'(is_rtype), 32'd0);
    check("lw_rt", 32'(rt), 32'd2);
    check("lw_pc", pc_out, 32'd0);
    step();
    check("lw_halted", 32'(halted), 32'd1);
`endif

    // Asynchronous reset mid-run
    load(6'd0, W_ADD0); load(6'd1, W_ADD1); load(6'd2, W_BRK);
    out_ready = 1'b0;
    do_start();
    step();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_halted", 32'(halted), 32'd0);
    check("rst_async_pc", pc_out, 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) step();
    check("post_rst_idle", 32'(out_valid), 32'd0);
    do_start();
    step();
    check("post_rst_pc", pc_out, 32'd0);
    check("post_rst_rs", 32'(rs), 32'd2);
    repeat (2) step();
    check("post_rst_halted", 32'(halted), 32'd1);

    // Program write during RUN is ignored; repeated in HALT it takes effect
    out_ready = 1'b0;
    do_start();
    step();
    load(6'd1, W_NEW1);
    out_ready = 1'b1;
    step();
    check("we_run_pc", pc_out, 32'd4);
    check("we_run_old_rs", 32'(rs), 32'd7);
    step();
    check("we_run_halted", 32'(halted), 32'd1);
    load(6'd1, W_NEW1);
    do_start();
    step();
    check("we_halt_pc0", pc_out, 32'd0);
    step();
    check("we_halt_pc", pc_out, 32'd4);
    check("we_halt_rs", 32'(rs), 32'd9);
    check("we_halt_rt", 32'(rt), 32'd10);
    check("we_halt_rd", 32'(rd), 32'd8);
    step();

    // DEPTH=4 wrap: rd of word i is i+1
    for (int i = 0; i < 4; i++) begin
      d4_we = 1'b1; d4_waddr = 2'(i); d4_wdata = 32'h20 | (32'(i + 1) << 11);
      step();
    end
    d4_we = 1'b0;
    d4_start = 1'b1;
    step();
    d4_start = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("wrap_valid", 32'(d4_valid), 32'd1);
      check("wrap_pc", d4_pc_out, 32'(4 * i));
      check("wrap_rd", 32'(d4_rd), 32'((i % 4) + 1));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
